seg_scan_ctrl: RTL and testbench

Parametrised multiplexed seven-segment scan controller: drives `DIGITS` common-anode digits from a packed hex value, one digit at a time, with a programmable dwell per digit. It replaces the fixed 8-digit, 1 s-per-digit scanner as the single display back-end for all boards. New values are loaded with a request/acknowledge handshake and committed only at frame boundaries, so a displayed frame never mixes old and new digits.

---
 rtl/seg_scan_ctrl_if.sv | 23 ++
 rtl/seg_scan_ctrl.sv | 91 +++++++++
 tb/tb_seg_scan_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: load handshake and display drive bundle for seg_scan_ctrl
interface seg_scan_ctrl_if #(
  parameter int DIGITS = 8
);
  logic                  disp_en;
  logic                  load_req;
  logic [4*DIGITS-1:0]   data_in;
  logic [DIGITS-1:0]     dp_in;
  logic                  load_busy;
  logic                  load_ack;
  logic [DIGITS-1:0]     sel;
  logic [6:0]            seg;
  logic                  dp;
  logic                  frame_end;
  modport master (
    output disp_en, load_req, data_in, dp_in,
    input  load_busy, load_ack, sel, seg, dp, frame_end
  );
  modport slave (
    input  disp_en, load_req, data_in, dp_in,
    output load_busy, load_ack, sel, seg, dp, frame_end
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: frame-synchronous multiplexed 7-seg scanner; define SEG_LZB_EN for leading-zero blanking
module seg_scan_ctrl #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int DIGITS   = 8
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  seg_scan_ctrl_if.slave bus
);
  localparam int DWELL = CLK_FREQ / SCAN_HZ;
  localparam int CW    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  if (DWELL < 2) begin : g_dwell_chk
    $error("seg_scan_ctrl: CLK_FREQ/SCAN_HZ must be at least 2");
  end
  if (DIGITS < 1 || DIGITS > 16) begin : g_digits_chk
    $error("seg_scan_ctrl: DIGITS must be in 1..16");
  end
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   disp_q, disp_d, pend_q, pend_d;
  logic [DIGITS-1:0]     disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic                  busy_q, busy_d, ack_q, ack_d, fe_q, fe_d;
  logic [DIGITS-1:0]     sel_q, sel_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  tick, wrap, commit, blank;
  always_comb begin
    tick      = cnt_q == CW'(DWELL - 1);
    wrap      = tick && idx_q == IW'(DIGITS - 1);
    commit    = wrap && busy_q;
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    idx_d     = wrap ? '0 : tick ? idx_q + 1'b1 : idx_q;
    disp_d    = commit ? pend_q : disp_q;
    disp_dp_d = commit ? pend_dp_q : disp_dp_q;
    pend_d    = bus.load_req ? bus.data_in : pend_q;
    pend_dp_d = bus.load_req ? bus.dp_in : pend_dp_q;
    // a same-cycle request re-arms busy after the boundary commits the older value
    busy_d    = bus.load_req || (busy_q && !wrap);
    ack_d     = commit;
    fe_d      = wrap;
`ifdef SEG_LZB_EN
    blank     = idx_q != '0 && (disp_q >> {idx_q, 2'b00}) == '0;
`else
    blank     = 1'b0;
`endif
    seg_d     = blank ? 7'h7F : HEX[disp_q[4*idx_q +: 4]];
    dp_d      = ~disp_dp_q[idx_q];
    sel_d     = bus.disp_en ? ~(DIGITS'(1) << idx_q) : '1;
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      disp_q    <= '0;
      disp_dp_q <= '0;
      pend_q    <= '0;
      pend_dp_q <= '0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      fe_q      <= 1'b0;
      sel_q     <= '1;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      disp_dp_q <= disp_dp_d;
      pend_q    <= pend_d;
      pend_dp_q <= pend_dp_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      fe_q      <= fe_d;
      sel_q     <= sel_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end
  assign bus.load_busy = busy_q;
  assign bus.load_ack  = ack_q;
  assign bus.frame_end = fe_q;
  assign bus.sel       = sel_q;
  assign bus.seg       = seg_q;
  assign bus.dp        = dp_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed and random stimulus against a time-based reference model
module tb_seg_scan_ctrl;
  localparam int D     = 4;
  localparam int DW    = 4;
  localparam int FRAME = D * DW;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  seg_scan_ctrl_if #(.DIGITS(D)) bus ();
  seg_scan_ctrl #(.CLK_FREQ(100), .SCAN_HZ(25), .DIGITS(D)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );
  logic [6:0] hex_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  int errors = 0;
  int checks = 0;
  int acks   = 0;
  int n      = 0;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dp, m_pdp, e_sel;
  logic [6:0]  e_seg;
  logic        m_busy, e_dp, e_fe, e_ack;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  // n counts clock edges since reset released; the displayed digit and frame position follow from it
  task automatic model_edge();
    int dg;
    logic [15:0] rest;
    logic bnd;
    if (rst) begin
      n = 0; m_disp = '0; m_pend = '0; m_dp = '0; m_pdp = '0; m_busy = 1'b0;
      e_sel = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fe = 1'b0; e_ack = 1'b0;
    end else begin
      dg   = (n / DW) % D;
      bnd  = (n % FRAME) == FRAME - 1;
      rest = m_disp >> (4 * dg);
      e_sel = bus.disp_en ? ~(4'(1) << dg) : 4'hF;
      e_seg = hex_tab[rest[3:0]];
`ifdef SEG_LZB_EN
      if (dg > 0 && rest == 16'h0) e_seg = 7'h7F;
`endif
      e_dp  = ~m_dp[dg];
      e_fe  = bnd;
      e_ack = bnd && m_busy;
      if (e_ack) begin
        m_disp = m_pend;
        m_dp   = m_pdp;
      end
      if (bus.load_req) begin
        m_pend = bus.data_in;
        m_pdp  = bus.dp_in;
        m_busy = 1'b1;
      end else if (bnd) m_busy = 1'b0;
      n++;
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("sel", bus.sel, e_sel);
    check("seg", bus.seg, e_seg);
    check("dp", bus.dp, e_dp);
    check("frame_end", bus.frame_end, e_fe);
    check("load_ack", bus.load_ack, e_ack);
    check("load_busy", bus.load_busy, m_busy);
    if (bus.load_ack) acks++;
  endtask
  task automatic run(input int k);
    repeat (k) step();
  endtask
  task automatic load(input logic [15:0] v, input logic [3:0] p);
    bus.load_req = 1'b1;
    bus.data_in  = v;
    bus.dp_in    = p;
    step();
    bus.load_req = 1'b0;
  endtask
  initial begin
    bus.disp_en  = 1'b1;
    bus.load_req = 1'b0;
    bus.data_in  = '0;
    bus.dp_in    = '0;
    run(2);
    rst = 1'b0;
    run(20);
    acks = 0;
    run(2);
    load(16'h12AF, 4'b0100);
    run(30);
    check("ack_12AF_once", acks, 1);
    acks = 0;
    load(16'h1111, 4'b0000);
    run(3);
    load(16'h2222, 4'b0001);
    run(30);
    check("ack_double_once", acks, 1);
    load(16'h3333, 4'b1000);
    for (int i = 0; i < FRAME && n % FRAME != FRAME - 1; i++) step();
    acks = 0;
    load(16'h4444, 4'b0010);
    check("bnd_ack", bus.load_ack, 1);
    check("bnd_busy", bus.load_busy, 1);
    run(FRAME + 2);
    check("bnd_acks_total", acks, 2);
    load(16'h5555, 4'b1111);
    step();
    rst = 1'b1;
    step();
    check("rst_sel", bus.sel, 4'hF);
    check("rst_seg", bus.seg, 7'h7F);
    rst = 1'b0;
    acks = 0;
    run(2 * FRAME);
    check("rst_no_ack", acks, 0);
    load(16'h0050, 4'b0000);
    run(2 * FRAME + 2);
    load(16'h0000, 4'b0100);
    run(2 * FRAME + 2);
    for (int i = 0; i < 500; i++) begin
      rst          = $urandom_range(0, 149) == 0;
      bus.disp_en  = $urandom_range(0, 7) != 0;
      bus.load_req = $urandom_range(0, 9) == 0;
      bus.data_in  = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom & 32'h00F0);
      bus.dp_in    = 4'($urandom);
      step();
    end
    rst = 1'b0;
    bus.load_req = 1'b0;
    run(FRAME);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
